sat_engine_ctrl: RTL

- Bin-level sequencer for the SAT engine: the initiator side of the apply/done handshakes that the load, implication, decision, conflict-analysis and update units answer.
- Per bin, drives one pulse per phase: load clauses, then repeated imply/decide, analyze on conflict, update state.
- Reports a per-bin verdict and backtrack target to the bin manager.
- Sits between the bin manager (above) and the engine's functional units (below).

---
 rtl/sat_engine_ctrl.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/sat_engine_ctrl.sv
// sat_engine_ctrl: per-bin sequencer driving apply/done handshakes to the SAT engine units.
// Optional watchdog: define SAT_CTRL_TIMEOUT_EN to enable it (limit set by MAX_WAIT).
module sat_engine_ctrl #(
  parameter int WIDTH_LVL = 15,
  parameter int WIDTH_BIN = 10,
  parameter int MAX_WAIT  = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_bin_i,
  input  logic [WIDTH_BIN-1:0] cur_bin_num_i,
  output logic                 apply_load_o,
  output logic                 apply_implication_o,
  output logic                 apply_decide_o,
  output logic                 apply_analyze_o,
  output logic                 apply_update_o,
  input  logic                 done_load_i,
  input  logic                 done_imply_i,
  input  logic                 done_decide_i,
  input  logic                 done_analyze_i,
  input  logic                 done_update_i,
  input  logic                 conflict_i,
  input  logic                 all_decided_i,
  input  logic [WIDTH_BIN-1:0] bkt_bin_num_i,
  input  logic [WIDTH_LVL-1:0] bkt_lvl_i,
  output logic                 busy_o,
  output logic                 done_bin_o,
  output logic [1:0]           result_o,
  output logic [WIDTH_BIN-1:0] bkt_bin_num_o,
  output logic [WIDTH_LVL-1:0] cur_lvl_o,
  output logic [15:0]          conflict_cnt_o,
  output logic                 timeout_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_IMPLY, S_DECIDE, S_ANALYZE, S_UPDATE, S_DONE
  } state_t;

  localparam logic [1:0] RES_NONE  = 2'd0;
  localparam logic [1:0] RES_SAT   = 2'd1;
  localparam logic [1:0] RES_BKT   = 2'd2;
  localparam logic [1:0] RES_UNSAT = 2'd3;

  state_t               state, state_nxt;
  logic                 apply_load_nxt, apply_imply_nxt, apply_decide_nxt;
  logic                 apply_analyze_nxt, apply_update_nxt;
  logic                 busy_nxt, done_bin_nxt;
  logic [1:0]           result_nxt;
  logic [WIDTH_BIN-1:0] bkt_bin_nxt;
  logic [WIDTH_LVL-1:0] lvl_nxt;
  logic [15:0]          cnt_nxt;
  logic                 in_apply, phase_done, expire;

  // A phase's done is only honoured once its apply pulse has gone.
  assign in_apply = apply_load_o | apply_implication_o | apply_decide_o |
                    apply_analyze_o | apply_update_o;

  always_comb begin
    phase_done = 1'b0;
    case (state)
      S_LOAD:    phase_done = done_load_i;
      S_IMPLY:   phase_done = done_imply_i;
      S_DECIDE:  phase_done = done_decide_i;
      S_ANALYZE: phase_done = done_analyze_i;
      S_UPDATE:  phase_done = done_update_i;
      default:   phase_done = 1'b0;
    endcase
    phase_done = phase_done & ~in_apply;
  end

  always_comb begin
    state_nxt         = state;
    apply_load_nxt    = 1'b0;
    apply_imply_nxt   = 1'b0;
    apply_decide_nxt  = 1'b0;
    apply_analyze_nxt = 1'b0;
    apply_update_nxt  = 1'b0;
    done_bin_nxt      = 1'b0;
    result_nxt        = result_o;
    bkt_bin_nxt       = bkt_bin_num_o;
    lvl_nxt           = cur_lvl_o;
    cnt_nxt           = conflict_cnt_o;

    case (state)
      S_IDLE: begin
        if (start_bin_i) begin
          state_nxt      = S_LOAD;
          apply_load_nxt = 1'b1;
          lvl_nxt        = '0;
          cnt_nxt        = '0;
          result_nxt     = RES_NONE;
        end
      end
      S_LOAD: begin
        if (phase_done) begin
          state_nxt       = S_IMPLY;
          apply_imply_nxt = 1'b1;
        end
      end
      S_IMPLY: begin
        if (phase_done) begin
          // conflict outranks all_decided
          if (conflict_i && (cur_lvl_o == '0) && (cur_bin_num_i == '0)) begin
            state_nxt    = S_DONE;
            done_bin_nxt = 1'b1;
            result_nxt   = RES_UNSAT;
          end else if (conflict_i) begin
            if (conflict_cnt_o != 16'hFFFF) cnt_nxt = conflict_cnt_o + 16'd1;
            state_nxt         = S_ANALYZE;
            apply_analyze_nxt = 1'b1;
          end else if (all_decided_i) begin
            state_nxt        = S_UPDATE;
            apply_update_nxt = 1'b1;
            result_nxt       = RES_SAT;
          end else begin
            state_nxt        = S_DECIDE;
            apply_decide_nxt = 1'b1;
          end
        end
      end
      S_DECIDE: begin
        if (phase_done) begin
          if (cur_lvl_o != '1) lvl_nxt = cur_lvl_o + WIDTH_LVL'(1);
          state_nxt       = S_IMPLY;
          apply_imply_nxt = 1'b1;
        end
      end
      S_ANALYZE: begin
        if (phase_done) begin
          if (bkt_bin_num_i == cur_bin_num_i) begin
            lvl_nxt         = bkt_lvl_i;
            state_nxt       = S_IMPLY;
            apply_imply_nxt = 1'b1;
          end else begin
            bkt_bin_nxt      = bkt_bin_num_i;
            result_nxt       = RES_BKT;
            state_nxt        = S_UPDATE;
            apply_update_nxt = 1'b1;
          end
        end
      end
      S_UPDATE: begin
        if (phase_done) begin
          state_nxt    = S_DONE;
          done_bin_nxt = 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Watchdog expiry only fires while waiting without a done, so no apply is pending here.
    if (expire) begin
      state_nxt    = S_DONE;
      done_bin_nxt = 1'b1;
      result_nxt   = RES_NONE;
    end

    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= S_IDLE;
      apply_load_o        <= 1'b0;
      apply_implication_o <= 1'b0;
      apply_decide_o      <= 1'b0;
      apply_analyze_o     <= 1'b0;
      apply_update_o      <= 1'b0;
      busy_o              <= 1'b0;
      done_bin_o          <= 1'b0;
      result_o            <= RES_NONE;
      bkt_bin_num_o       <= '0;
      cur_lvl_o           <= '0;
      conflict_cnt_o      <= '0;
    end else begin
      state               <= state_nxt;
      apply_load_o        <= apply_load_nxt;
      apply_implication_o <= apply_imply_nxt;
      apply_decide_o      <= apply_decide_nxt;
      apply_analyze_o     <= apply_analyze_nxt;
      apply_update_o      <= apply_update_nxt;
      busy_o              <= busy_nxt;
      done_bin_o          <= done_bin_nxt;
      result_o            <= result_nxt;
      bkt_bin_num_o       <= bkt_bin_nxt;
      cur_lvl_o           <= lvl_nxt;
      conflict_cnt_o      <= cnt_nxt;
    end
  end

`ifdef SAT_CTRL_TIMEOUT_EN
  localparam logic [10:0] WAIT_LIMIT = 11'(MAX_WAIT);

  logic [10:0] wait_cnt, wait_cnt_nxt;
  logic        timeout_nxt, in_phase;

  assign in_phase = (state == S_LOAD) || (state == S_IMPLY) || (state == S_DECIDE) ||
                    (state == S_ANALYZE) || (state == S_UPDATE);

  // The apply cycle counts as the first elapsed cycle of the wait.
  always_comb begin
    wait_cnt_nxt = wait_cnt;
    expire       = 1'b0;
    if (in_apply) begin
      wait_cnt_nxt = 11'd1;
    end else if (in_phase && !phase_done) begin
      wait_cnt_nxt = wait_cnt + 11'd1;
      expire       = (wait_cnt_nxt >= WAIT_LIMIT);
    end
  end

  always_comb begin
    timeout_nxt = timeout_o;
    if ((state == S_IDLE) && start_bin_i) timeout_nxt = 1'b0;
    if (expire) timeout_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt  <= '0;
      timeout_o <= 1'b0;
    end else begin
      wait_cnt  <= wait_cnt_nxt;
      timeout_o <= timeout_nxt;
    end
  end
`else
  assign expire    = 1'b0;
  assign timeout_o = 1'b0;
`endif

endmodule
